two_digit_entry_ctrl: RTL and testbench
=======================================

TWO_DIGIT_ENTRY_CTRL -- requirements
Module: two_digit_entry_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000000, max cycles allowed between first and second digit (1 s at 50 MHz).
REQ-002 Parameter MAX_VALUE, default 99, largest accepted two-digit value.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 key_code  input  8  keypad code; values 0..9 are digits, all others non-digits.
REQ-006 key_valid  input  1  one-cycle strobe qualifying key_code.
REQ-007 cancel  input  1  abort current entry.
REQ-008 out_ready  input  1  consumer accepts value when high with value_valid.
REQ-009 value  output  7  assembled value, d1*10+d2 (0..99).
REQ-010 value_valid  output  1  value available; held until accepted.
REQ-011 err  output  1  one-cycle error pulse.
REQ-012 err_code  output  2  00 none, 01 non-digit, 10 out of range, 11 timeout; valid while err=1, else 00.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, GOT1, CHECK, OUT, ERR.
REQ-015 IDLE: key_valid captures key_code into d1 register, clears timer, -> GOT1.
REQ-016 GOT1: key_valid captures key_code into d2 register, -> CHECK; timer increments each cycle without key_valid.
REQ-017 GOT1: timer reaching TIMEOUT_CYCLES consecutive idle cycles -> ERR with err_code 11; key_valid on the expiry cycle wins (-> CHECK).
REQ-018 CHECK (exactly one cycle): either digit non-digit -> ERR code 01; both digits, d1*10+d2 > MAX_VALUE -> ERR code 10; otherwise -> OUT.
REQ-019 Non-digit check has priority over range check.
REQ-020 Latency: second key_valid in cycle N -> value_valid high in cycle N+2.
REQ-021 OUT: value_valid=1, value stable; out_ready high -> IDLE next cycle; key_valid ignored.
REQ-022 ERR: err=1 and err_code driven for exactly one cycle, -> IDLE.
REQ-023 cancel high in GOT1, CHECK or OUT -> IDLE next cycle, no value_valid and no err produced; cancel has priority over key_valid, timeout and out_ready.
REQ-024 cancel in IDLE or ERR has no effect; key_valid in CHECK or ERR is dropped.
REQ-025 Arithmetic: d1*10+d2 computed at 7 bits from 4-bit digit fields; only evaluated when both digits valid.
REQ-026 Timer width $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.
REQ-027 value holds last accepted result outside OUT; value_valid low outside OUT.

Reset
REQ-028 reset asserted: state IDLE, d1/d2/timer 0, value 0, value_valid 0, err 0, err_code 00, busy 0, regardless of clock.
REQ-029 reset mid-entry or mid-OUT discards data; first post-reset key_valid is treated as d1.

Structure
REQ-030 Shared package home_sim_pkg holds state encodings, err_code constants and DIGIT_MAX (9).
REQ-031 One sub-module digit_valid: combinational 8-bit code -> 1 when 0..9; instantiated twice (d1, d2).
REQ-032 Target size 120-400 lines RTL; no memories, no multipliers beyond shift-add *10.

Verification (bench uses TIMEOUT_CYCLES=8, MAX_VALUE=99 unless noted)
REQ-033 Keys 2 then 7, out_ready=1 -> value=27, value_valid for 1 cycle, 2 cycles after second strobe, busy back to 0.
REQ-034 Keys 4 then 0x41 -> err=1, err_code=01 for one cycle, no value_valid.
REQ-035 MAX_VALUE=40, keys 5 then 3 -> err_code=10; keys 4 then 0 -> value=40.
REQ-036 Key 1 then 8 idle cycles -> err_code=11 on timeout; key 1 then second key on 8th cycle -> accepted, no err.
REQ-037 Keys 9,9 with out_ready=0 for 5 cycles -> value_valid held at 99 until out_ready; cancel+key_valid same cycle in GOT1 -> IDLE, key dropped.
REQ-038 reset pulse asserted between edges in GOT1 -> outputs at reset values immediately; keys 3,6 afterwards -> value=36.

Source files
------------

// File: rtl/home_sim_pkg.sv
// Shared encodings and helpers for the two-digit keypad entry controller.
package home_sim_pkg;

    localparam int unsigned KEY_W     = 8;
    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned VALUE_W   = 7;
    localparam int unsigned DIGIT_MAX = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GOT1  = 3'd1,
        ST_CHECK = 3'd2,
        ST_OUT   = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_NONDIGIT = 2'b01,
        ERR_RANGE    = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } err_code_e;

    // d1*10 + d2 as shift-add: (d1<<3) + (d1<<1) + d2
    function automatic logic [VALUE_W-1:0] tens_plus_units(
        input logic [DIGIT_W-1:0] tens,
        input logic [DIGIT_W-1:0] units
    );
        logic [VALUE_W-1:0] t;
        t = VALUE_W'(tens);
        return (t << 3) + (t << 1) + VALUE_W'(units);
    endfunction

endpackage

// File: rtl/digit_valid.sv
// Flags a keypad code as a decimal digit (0..9).
module digit_valid
    import home_sim_pkg::*;
(
    input  logic [KEY_W-1:0] code_i,
    output logic             is_digit_c
);

    assign is_digit_c = (code_i <= KEY_W'(DIGIT_MAX));

endmodule

// File: rtl/two_digit_entry_ctrl.sv
// Collects two keypad digits, validates them and presents d1*10+d2 with a
// valid/ready handshake; reports non-digit, range and inter-key timeout errors.
module two_digit_entry_ctrl
    import home_sim_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned MAX_VALUE      = 99
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [KEY_W-1:0]   key_code,
    input  logic               key_valid,
    input  logic               cancel,
    input  logic               out_ready,
    output logic [VALUE_W-1:0] value,
    output logic               value_valid,
    output logic               err,
    output logic [1:0]         err_code,
    output logic               busy
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e               state_q, state_d;
    logic [KEY_W-1:0]     d1_q, d1_d;
    logic [KEY_W-1:0]     d2_q, d2_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [VALUE_W-1:0]   value_q, value_d;
    logic [VALUE_W-1:0]   acc_q, acc_d;
    err_code_e            err_code_q, err_code_d;
    logic                 value_valid_q, err_q, busy_q;

    logic                 d1_ok_c, d2_ok_c;
    logic [VALUE_W-1:0]   sum_c;
    logic [TIMER_W-1:0]   timer_inc_c;
    logic                 timer_expired_c;

    digit_valid u_d1_valid (.code_i(d1_q), .is_digit_c(d1_ok_c));
    digit_valid u_d2_valid (.code_i(d2_q), .is_digit_c(d2_ok_c));

    // Sum is only formed from validated digits; non-digit codes never reach the adder.
    assign sum_c = (d1_ok_c && d2_ok_c)
                 ? tens_plus_units(d1_q[DIGIT_W-1:0], d2_q[DIGIT_W-1:0])
                 : '0;

    assign timer_inc_c     = (timer_q == TIMER_W'(TIMEOUT_CYCLES)) ? timer_q : timer_q + TIMER_W'(1);
    assign timer_expired_c = (timer_inc_c == TIMER_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            d1_q          <= '0;
            d2_q          <= '0;
            timer_q       <= '0;
            value_q       <= '0;
            acc_q         <= '0;
            err_code_q    <= ERR_NONE;
            value_valid_q <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            d1_q          <= d1_d;
            d2_q          <= d2_d;
            timer_q       <= timer_d;
            value_q       <= value_d;
            acc_q         <= acc_d;
            err_code_q    <= err_code_d;
            value_valid_q <= (state_d == ST_OUT);
            err_q         <= (state_d == ST_ERR);
            busy_q        <= (state_d != ST_IDLE);
        end
    end

    always_comb begin
        state_d    = state_q;
        d1_d       = d1_q;
        d2_d       = d2_q;
        timer_d    = timer_q;
        value_d    = value_q;
        acc_d      = acc_q;
        err_code_d = ERR_NONE;

        unique case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    d1_d    = key_code;
                    timer_d = '0;
                    state_d = ST_GOT1;
                end
            end
            ST_GOT1: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (key_valid) begin
                    d2_d    = key_code;
                    state_d = ST_CHECK;
                end else begin
                    timer_d = timer_inc_c;
                    if (timer_expired_c) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_TIMEOUT;
                    end
                end
            end
            ST_CHECK: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (!d1_ok_c || !d2_ok_c) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_NONDIGIT;
                end else if (32'(sum_c) > MAX_VALUE) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_RANGE;
                end else begin
                    state_d = ST_OUT;
                    value_d = sum_c;
                end
            end
            ST_OUT: begin
                // A cancelled result is never accepted, so fall back to the last accepted one.
                if (cancel) begin
                    state_d = ST_IDLE;
                    value_d = acc_q;
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                    acc_d   = value_q;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_two_digit_entry_ctrl.sv
// Directed bench for two_digit_entry_ctrl: a MAX_VALUE=99 and a MAX_VALUE=40 instance share stimulus.
module tb_two_digit_entry_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] key_code;
    logic       key_valid;
    logic       cancel;
    logic       out_ready;

    logic [6:0] value_a, value_b;
    logic       vv_a, vv_b, err_a, err_b, busy_a, busy_b;
    logic [1:0] code_a, code_b;

    int n_checks = 0;
    int n_fail   = 0;

    two_digit_entry_ctrl #(.TIMEOUT_CYCLES(8), .MAX_VALUE(99)) dut (
        .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
        .cancel(cancel), .out_ready(out_ready), .value(value_a), .value_valid(vv_a),
        .err(err_a), .err_code(code_a), .busy(busy_a)
    );

    two_digit_entry_ctrl #(.TIMEOUT_CYCLES(8), .MAX_VALUE(40)) dut40 (
        .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
        .cancel(cancel), .out_ready(out_ready), .value(value_b), .value_valid(vv_b),
        .err(err_b), .err_code(code_b), .busy(busy_b)
    );

    wire [11:0] obs_a = {vv_a, value_a, err_a, code_a, busy_a};
    wire [11:0] obs_b = {vv_b, value_b, err_b, code_b, busy_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] ev(input int vv, input int v, input int e, input int c, input int b);
        return {1'(vv), 7'(v), 1'(e), 2'(c), 1'(b)};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed vv=%0d value=%0d err=%0d code=%0d busy=%0d, expected vv=%0d value=%0d err=%0d code=%0d busy=%0d",
                   tag, obs[11], obs[10:4], obs[3], obs[2:1], obs[0],
                   exp[11], exp[10:4], exp[3], exp[2:1], exp[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; key_code = 8'd0; key_valid = 1'b0; cancel = 1'b0; out_ready = 1'b1;
        #1;
        chk("reset_a", obs_a, ev(0, 0, 0, 0, 0));
        chk("reset_b", obs_b, ev(0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        step();

        // 2 then 7, consumer ready
        key_valid = 1'b1; key_code = 8'd2; step();
        chk("t27_got1", obs_a, ev(0, 0, 0, 0, 1));
        key_code = 8'd7; step(); key_valid = 1'b0;
        chk("t27_check", obs_a, ev(0, 0, 0, 0, 1));
        step();
        chk("t27_out", obs_a, ev(1, 27, 0, 0, 1));
        step();
        chk("t27_idle", obs_a, ev(0, 27, 0, 0, 0));

        // 4 then non-digit 0x41
        key_valid = 1'b1; key_code = 8'd4; step();
        key_code = 8'h41; step(); key_valid = 1'b0;
        step();
        chk("nondigit_err", obs_a, ev(0, 27, 1, 1, 1));
        step();
        chk("nondigit_clear", obs_a, ev(0, 27, 0, 0, 0));

        // range limit on the MAX_VALUE=40 instance
        key_valid = 1'b1; key_code = 8'd5; step();
        key_code = 8'd3; step(); key_valid = 1'b0;
        step();
        chk("range53_b", obs_b, ev(0, 27, 1, 2, 1));
        chk("range53_a_ok", obs_a, ev(1, 53, 0, 0, 1));
        step();
        chk("range53_b_clear", obs_b, ev(0, 27, 0, 0, 0));
        key_valid = 1'b1; key_code = 8'd4; step();
        key_code = 8'd0; step(); key_valid = 1'b0;
        step();
        chk("range40_b_out", obs_b, ev(1, 40, 0, 0, 1));
        step();
        chk("range40_b_idle", obs_b, ev(0, 40, 0, 0, 0));

        // timeout: key 1 then 8 idle cycles
        key_valid = 1'b1; key_code = 8'd1; step(); key_valid = 1'b0;
        repeat (7) step();
        chk("tmo_before", obs_a, ev(0, 40, 0, 0, 1));
        step();
        chk("tmo_err", obs_a, ev(0, 40, 1, 3, 1));
        step();
        chk("tmo_clear", obs_a, ev(0, 40, 0, 0, 0));

        // second key on the expiry cycle wins
        key_valid = 1'b1; key_code = 8'd1; step(); key_valid = 1'b0;
        repeat (7) step();
        key_valid = 1'b1; key_code = 8'd5; step(); key_valid = 1'b0;
        chk("tmo_edge_check", obs_a, ev(0, 40, 0, 0, 1));
        step();
        chk("tmo_edge_out", obs_a, ev(1, 15, 0, 0, 1));
        step();
        chk("tmo_edge_idle", obs_a, ev(0, 15, 0, 0, 0));

        // 9,9 held while consumer stalls
        out_ready = 1'b0;
        key_valid = 1'b1; key_code = 8'd9; step();
        step(); key_valid = 1'b0;
        step();
        chk("hold99_0", obs_a, ev(1, 99, 0, 0, 1));
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("hold99_%0d", i + 1), obs_a, ev(1, 99, 0, 0, 1));
        end
        out_ready = 1'b1; step();
        chk("hold99_release", obs_a, ev(0, 99, 0, 0, 0));

        // cancel beats key_valid in GOT1; next key is a fresh d1
        key_valid = 1'b1; key_code = 8'd2; step();
        key_code = 8'd3; cancel = 1'b1; step();
        key_valid = 1'b0; cancel = 1'b0;
        chk("cancel_got1", obs_a, ev(0, 99, 0, 0, 0));
        key_valid = 1'b1; key_code = 8'd1; step();
        key_code = 8'd4; step(); key_valid = 1'b0;
        step();
        chk("after_cancel_out", obs_a, ev(1, 14, 0, 0, 1));
        step();

        // cancel in OUT beats out_ready; value reverts to last accepted
        key_valid = 1'b1; key_code = 8'd5; step();
        step(); key_valid = 1'b0;
        out_ready = 1'b0; step();
        chk("cancel_out_pre", obs_a, ev(1, 55, 0, 0, 1));
        cancel = 1'b1; out_ready = 1'b1; step();
        cancel = 1'b0;
        chk("cancel_out", obs_a, ev(0, 14, 0, 0, 0));

        // asynchronous reset mid-entry
        key_valid = 1'b1; key_code = 8'd3; step(); key_valid = 1'b0;
        chk("rst_pre", obs_a, ev(0, 14, 0, 0, 1));
        #2 reset = 1'b1;
        #1;
        chk("rst_async_a", obs_a, ev(0, 0, 0, 0, 0));
        chk("rst_async_b", obs_b, ev(0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        key_valid = 1'b1; key_code = 8'd3; step();
        key_code = 8'd6; step(); key_valid = 1'b0;
        step();
        chk("post_rst_36", obs_a, ev(1, 36, 0, 0, 1));
        step();
        chk("post_rst_idle", obs_a, ev(0, 36, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
